// File: rtl/watchdog_timer_core_pkg.sv
// Shared constants for the watchdog: default limits, counter width and the
// reduced parameter pair used for formal runs and the bench.
package watchdog_pkg;

    localparam int unsigned WD_CNT_W           = 32;
    localparam int unsigned WD_TIMEOUT_DEFAULT = 125_000_000;
    localparam int unsigned WD_WARN_DEFAULT    = 100_000_000;

    localparam int unsigned WD_TIMEOUT_FORMAL  = 16;
    localparam int unsigned WD_WARN_FORMAL     = 12;

endpackage

// File: rtl/watchdog_timer_core_if.sv
// Control/status bundle between software-facing logic (master) and the
// watchdog core (slave).
interface watchdog_timer_core_if;
    import watchdog_pkg::*;

    logic                heartbeat;
    logic                force_reset;
    logic                enable;
    logic                triggered;
    logic                warning;
    logic [WD_CNT_W-1:0] counter;

    modport master (
        output heartbeat, force_reset, enable,
        input  triggered, warning, counter
    );

    modport slave (
        input  heartbeat, force_reset, enable,
        output triggered, warning, counter
    );

endinterface

// File: rtl/watchdog_timer_core.sv
// Heartbeat watchdog: counts cycles since the last service, warns near the
// limit and latches a trip flag. Formal properties under WATCHDOG_FORMAL_EN.
module watchdog_timer_core
    import watchdog_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = WD_TIMEOUT_DEFAULT,
    parameter int unsigned WARN_CYCLES    = WD_WARN_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    watchdog_timer_core_if.slave  wd
);

    localparam int unsigned CW = WD_CNT_W;
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] WARN_C    = CW'(WARN_CYCLES);

    if (TIMEOUT_CYCLES < 2 || WARN_CYCLES < 1 || WARN_CYCLES >= TIMEOUT_CYCLES) begin : g_param_chk
        $error("watchdog_timer_core: need 1 <= WARN_CYCLES < TIMEOUT_CYCLES, TIMEOUT_CYCLES >= 2");
    end

    logic [CW-1:0] counter_q, counter_d;
    logic          warning_q, warning_d;
    logic          triggered_q, triggered_d;
    logic [CW-1:0] cnt_inc;

    assign cnt_inc = counter_q + CW'(1);

    always_comb begin
        counter_d   = counter_q;
        warning_d   = warning_q;
        triggered_d = triggered_q;
        if (wd.force_reset) begin
            counter_d   = '0;
            warning_d   = 1'b0;
            triggered_d = 1'b0;
        end else if (!wd.enable) begin
            counter_d = '0;
            warning_d = 1'b0;
        end else if (triggered_q) begin
            // Re-pin the count after a disable/re-enable while tripped.
            counter_d = TIMEOUT_C;
            warning_d = 1'b0;
        end else if (wd.heartbeat) begin
            counter_d = '0;
            warning_d = 1'b0;
        end else begin
            counter_d = cnt_inc;
            if (cnt_inc >= WARN_C) warning_d = 1'b1;
            if (cnt_inc == TIMEOUT_C) begin
                triggered_d = 1'b1;
                warning_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter_q   <= '0;
            warning_q   <= 1'b0;
            triggered_q <= 1'b0;
        end else begin
            counter_q   <= counter_d;
            warning_q   <= warning_d;
            triggered_q <= triggered_d;
        end
    end

    assign wd.counter   = counter_q;
    assign wd.warning   = warning_q;
    assign wd.triggered = triggered_q;

`ifdef WATCHDOG_FORMAL_EN
    logic f_past_valid = 1'b0;
    always @(posedge clk) f_past_valid <= 1'b1;

    always @(*) if (!f_past_valid) assume (rst);

    always @(*) begin
        assert (counter_q <= TIMEOUT_C);
        if (triggered_q) assert (!warning_q);
        if (warning_q)   assert (counter_q >= WARN_C);
    end

    a_trip_count: assert property (@(posedge clk) disable iff (rst)
        (f_past_valid && triggered_q && $past(wd.enable) && !$past(rst)) |-> counter_q == TIMEOUT_C);
    a_trip_cause: assert property (@(posedge clk) disable iff (rst)
        (f_past_valid && $rose(triggered_q) && !$past(rst)) |-> $past(wd.enable && !wd.heartbeat));
    a_disable_clr: assert property (@(posedge clk) disable iff (rst)
        (f_past_valid && !wd.enable) |=> counter_q == '0);

    c_trip: cover property (@(posedge clk) $rose(triggered_q));
    c_trip_rst_rearm: cover property (@(posedge clk)
        triggered_q ##[1:$] rst ##[1:$] (!rst && wd.enable && !triggered_q));
`endif

endmodule

// File: tb/tb_watchdog_timer_core.sv
// Scoreboard bench for watchdog_timer_core (TIMEOUT=16, WARN=12): directed
// phases followed by random heartbeat/enable/clear traffic.
module tb_watchdog_timer_core;
    import watchdog_pkg::*;

    localparam int T = WD_TIMEOUT_FORMAL;
    localparam int W = WD_WARN_FORMAL;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    watchdog_timer_core_if wd_if ();

    watchdog_timer_core #(.TIMEOUT_CYCLES(T), .WARN_CYCLES(W)) dut (
        .clk (clk),
        .rst (rst),
        .wd  (wd_if.slave)
    );

    typedef struct {
        int unsigned cnt;
        bit          warn;
        bit          trip;
    } exp_t;

    exp_t exp_q[$];
    event async_ev;
    int   n_total = 0;
    int   n_pass  = 0;

    // Reference: elapsed cycles since last clear, plus a sticky trip flag.
    int unsigned m_elapsed = 0;
    bit          m_trip    = 0;

    function automatic exp_t model_out();
        exp_t e;
        e.cnt  = m_elapsed;
        e.trip = m_trip;
        e.warn = !m_trip && (m_elapsed >= W);
        return e;
    endfunction

    task automatic model_step(input bit r, input bit hb, input bit fr, input bit en);
        if (r || fr) begin
            m_elapsed = 0;
            m_trip    = 0;
        end else if (!en) begin
            m_elapsed = 0;
        end else if (m_trip) begin
            m_elapsed = T;
        end else if (hb) begin
            m_elapsed = 0;
        end else begin
            m_elapsed++;
            if (m_elapsed == T) m_trip = 1;
        end
    endtask

    task automatic cycle(input bit r, input bit hb, input bit fr, input bit en);
        @(negedge clk);
        rst               = r;
        wd_if.heartbeat   = hb;
        wd_if.force_reset = fr;
        wd_if.enable      = en;
        model_step(r, hb, fr, en);
        exp_q.push_back(model_out());
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        model_step(1, 0, 0, 1);
        exp_q.push_back(model_out());
        ->async_ev;
    endtask

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk or async_ev);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("counter",   wd_if.counter,   e.cnt);
                check("warning",   wd_if.warning,   e.warn);
                check("triggered", wd_if.triggered, e.trip);
            end
        end
    end

    initial begin : stimulus
        wd_if.heartbeat   = 1'b0;
        wd_if.force_reset = 1'b0;
        wd_if.enable      = 1'b1;

        // reset hold, then free-run to timeout and hold through heartbeats
        repeat (3) cycle(1, 0, 0, 1);
        repeat (20) cycle(0, 0, 0, 1);
        for (int i = 0; i < 10; i++) cycle(0, i[0], 0, 1);

        // clear trip, heartbeat every 10 cycles
        cycle(0, 0, 1, 1);
        for (int i = 0; i < 100; i++) cycle(0, (i % 10) == 9, 0, 1);
        // heartbeat landing exactly on the 16th edge
        cycle(0, 1, 0, 1);
        repeat (T - 1) cycle(0, 0, 0, 1);
        cycle(0, 1, 0, 1);
        repeat (3) cycle(0, 0, 0, 1);

        // disable at count 14, re-enable and run to trip
        cycle(0, 1, 0, 1);
        repeat (14) cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        repeat (T + 2) cycle(0, 0, 0, 1);

        // disable while tripped keeps trip; force_reset clears it
        repeat (3) cycle(0, 0, 0, 0);
        repeat (2) cycle(0, 1, 0, 1);
        cycle(0, 1, 1, 0);
        repeat (5) cycle(0, 0, 0, 1);

        // async reset at count 9
        cycle(0, 1, 0, 1);
        repeat (9) cycle(0, 0, 0, 1);
        async_reset();
        repeat (2) cycle(1, 0, 0, 1);
        repeat (T + 2) cycle(0, 0, 0, 1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) async_reset();
            cycle($urandom_range(0, 79) == 0,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 59) == 0,
                  $urandom_range(0, 29) != 0);
        end

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin : time_limit
        #200000;
        $display("FAIL time_limit: got timeout expected completion");
        $fatal(1, "bench time limit");
    end

endmodule
